// File: rtl/spi_adc_slave_emu_if.sv
// SPI pin bundle between an ADC master and the slave emulator.
interface spi_adc_slave_emu_if;
  logic spi_cs_n;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_cs_n, spi_sck, spi_mosi, input spi_miso, spi_miso_oe);
  modport slave  (input spi_cs_n, spi_sck, spi_mosi, output spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_adc_slave_emu.sv
// MCP3202-style SPI ADC slave emulator: oversamples the SPI pins on CLK, decodes
// start/SGL/channel/MSBF and shifts back the selected or differential value.
module spi_adc_slave_emu #(
  parameter  int CHANNELS    = 2,
  parameter  int RES_BITS    = 12,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_BITS     = $clog2(CHANNELS)
) (
  input  logic                         CLK,
  input  logic                         RST,
  spi_adc_slave_emu_if.slave           spi,
  input  logic [CHANNELS*RES_BITS-1:0] ch_data,
  output logic                         frame_done,
  output logic                         frame_abort,
  output logic [CH_BITS-1:0]           frame_ch,
  output logic                         frame_diff,
  output logic [RES_BITS-1:0]          frame_value
);

  localparam int CNT_W = $clog2(RES_BITS + CH_BITS + 2);
  localparam int IDX_W = $clog2(RES_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_CMD, S_NULL, S_DATA_MSB, S_DATA_LSB, S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_mosi_sync;
  logic                   r_cs_d, r_sck_d;
  logic                   w_cs_n, w_sck, w_mosi;
  logic                   w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_sgl, w_sgl_nxt;
  logic [CH_BITS-1:0]  r_ch, w_ch_nxt;
  logic                r_msbf, w_msbf_nxt;
  logic [RES_BITS-1:0] r_result, w_result_nxt;
  logic                r_miso, w_miso_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_done, w_done_nxt;
  logic                r_abort, w_abort_nxt;
  logic [CH_BITS-1:0]  r_frame_ch, w_frame_ch_nxt;
  logic                r_frame_diff, w_frame_diff_nxt;
  logic [RES_BITS-1:0] r_frame_value, w_frame_value_nxt;

  logic [RES_BITS-1:0] w_ch [CHANNELS];
  logic [RES_BITS-1:0] w_sel_val, w_pair_val, w_conv;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign w_ch[k] = ch_data[k*RES_BITS +: RES_BITS];
  end

  // Channel bits are complete by the MSBF sample; the pair channel differs only in its LSB.
  assign w_sel_val  = w_ch[r_ch];
  assign w_pair_val = w_ch[r_ch ^ CH_BITS'(1)];
  assign w_conv     = r_sgl ? w_sel_val
                    : ((w_sel_val > w_pair_val) ? w_sel_val - w_pair_val : '0);

  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;

  always_comb begin
    // NOTE: every next value is defaulted to its hold value first, so no path infers a latch.
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_sgl_nxt         = r_sgl;
    w_ch_nxt          = r_ch;
    w_msbf_nxt        = r_msbf;
    w_result_nxt      = r_result;
    w_miso_nxt        = r_miso;
    w_oe_nxt          = r_oe;
    w_done_nxt        = 1'b0;
    w_abort_nxt       = 1'b0;
    w_frame_ch_nxt    = r_frame_ch;
    w_frame_diff_nxt  = r_frame_diff;
    w_frame_value_nxt = r_frame_value;

    if (w_cs_rise) begin
      w_state_nxt = S_IDLE;
      w_miso_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
      w_abort_nxt = r_state inside {S_CMD, S_NULL, S_DATA_MSB, S_DATA_LSB};
    end else begin
      unique case (r_state)
        S_IDLE: if (w_cs_fall) begin
          w_state_nxt = S_WAIT_START;
          w_cnt_nxt   = '0;
          w_oe_nxt    = 1'b1;
          w_miso_nxt  = 1'b0;
        end
        S_WAIT_START: if (w_sck_rise && w_mosi) begin
          w_state_nxt = S_CMD;
          w_cnt_nxt   = '0;
        end
        S_CMD: if (w_sck_rise) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == '0) begin
            w_sgl_nxt = w_mosi;
          end else if (r_cnt <= CNT_W'(CH_BITS)) begin
            w_ch_nxt = (r_ch << 1) | CH_BITS'(w_mosi);
          end else begin
            w_msbf_nxt   = w_mosi;
            w_result_nxt = w_conv;
            w_state_nxt  = S_NULL;
          end
        end
        S_NULL: if (w_sck_fall) begin
          w_miso_nxt  = 1'b0;
          w_cnt_nxt   = CNT_W'(RES_BITS - 1);
          w_state_nxt = S_DATA_MSB;
        end
        S_DATA_MSB: if (w_sck_fall) begin
          w_miso_nxt = r_result[r_cnt[IDX_W-1:0]];
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (!r_msbf) begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_DATA_LSB;
          end else begin
            w_state_nxt       = S_DONE;
            w_done_nxt        = 1'b1;
            w_frame_ch_nxt    = r_ch;
            w_frame_diff_nxt  = ~r_sgl;
            w_frame_value_nxt = r_result;
          end
        end
        S_DATA_LSB: if (w_sck_fall) begin
          w_miso_nxt = r_result[r_cnt[IDX_W-1:0]];
          if (r_cnt != CNT_W'(RES_BITS - 1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_state_nxt       = S_DONE;
            w_done_nxt        = 1'b1;
            w_frame_ch_nxt    = r_ch;
            w_frame_diff_nxt  = ~r_sgl;
            w_frame_value_nxt = r_result;
          end
        end
        S_DONE: if (w_sck_fall) w_miso_nxt = 1'b0;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cs_sync     <= '1;
      r_sck_sync    <= '0;
      r_mosi_sync   <= '0;
      r_cs_d        <= 1'b1;
      r_sck_d       <= 1'b0;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sgl         <= 1'b0;
      r_ch          <= '0;
      r_msbf        <= 1'b0;
      r_result      <= '0;
      r_miso        <= 1'b0;
      r_oe          <= 1'b0;
      r_done        <= 1'b0;
      r_abort       <= 1'b0;
      r_frame_ch    <= '0;
      r_frame_diff  <= 1'b0;
      r_frame_value <= '0;
    end else begin
      r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      r_sck_sync    <= {r_sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
      r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
      r_cs_d        <= w_cs_n;
      r_sck_d       <= w_sck;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sgl         <= w_sgl_nxt;
      r_ch          <= w_ch_nxt;
      r_msbf        <= w_msbf_nxt;
      r_result      <= w_result_nxt;
      r_miso        <= w_miso_nxt;
      r_oe          <= w_oe_nxt;
      r_done        <= w_done_nxt;
      r_abort       <= w_abort_nxt;
      r_frame_ch    <= w_frame_ch_nxt;
      r_frame_diff  <= w_frame_diff_nxt;
      r_frame_value <= w_frame_value_nxt;
    end
  end

  assign spi.spi_miso    = r_miso;
  assign spi.spi_miso_oe = r_oe;
  assign frame_done      = r_done;
  assign frame_abort     = r_abort;
  assign frame_ch        = r_frame_ch;
  assign frame_diff      = r_frame_diff;
  assign frame_value     = r_frame_value;

endmodule

// File: tb/tb_spi_adc_slave_emu.sv
// Bench for spi_adc_slave_emu: a mode-0 SPI master drives two configurations,
// expected frames are queued up front and checked by independent monitors.
module tb_spi_adc_slave_emu;
  localparam int A_CH = 2, A_RES = 12, A_CB = 1;
  localparam int B_CH = 8, B_RES = 10, B_CB = 3;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic cs_a = 1'b1, cs_b = 1'b1, sck = 1'b0, mosi = 1'b0;
  int unsigned chv_a [A_CH];
  int unsigned chv_b [B_CH];
  logic [A_CH*A_RES-1:0] ch_data_a;
  logic [B_CH*B_RES-1:0] ch_data_b;

  always_comb begin
    ch_data_a = '0;
    for (int k = 0; k < A_CH; k++) ch_data_a[k*A_RES +: A_RES] = A_RES'(chv_a[k]);
  end
  always_comb begin
    ch_data_b = '0;
    for (int k = 0; k < B_CH; k++) ch_data_b[k*B_RES +: B_RES] = B_RES'(chv_b[k]);
  end

  spi_adc_slave_emu_if u_if_a ();
  spi_adc_slave_emu_if u_if_b ();
  assign u_if_a.spi_cs_n = cs_a;
  assign u_if_a.spi_sck  = sck;
  assign u_if_a.spi_mosi = mosi;
  assign u_if_b.spi_cs_n = cs_b;
  assign u_if_b.spi_sck  = sck;
  assign u_if_b.spi_mosi = mosi;

  logic             done_a, abort_a, fdiff_a;
  logic [0:0]       fch_a;
  logic [A_RES-1:0] fval_a;
  logic             done_b, abort_b, fdiff_b;
  logic [2:0]       fch_b;
  logic [B_RES-1:0] fval_b;

  spi_adc_slave_emu #(.CHANNELS(A_CH), .RES_BITS(A_RES), .SYNC_STAGES(SYNC)) u_dut_a (
    .CLK(clk), .RST(rst), .spi(u_if_a), .ch_data(ch_data_a),
    .frame_done(done_a), .frame_abort(abort_a), .frame_ch(fch_a),
    .frame_diff(fdiff_a), .frame_value(fval_a)
  );

  spi_adc_slave_emu #(.CHANNELS(B_CH), .RES_BITS(B_RES), .SYNC_STAGES(SYNC)) u_dut_b (
    .CLK(clk), .RST(rst), .spi(u_if_b), .ch_data(ch_data_b),
    .frame_done(done_b), .frame_abort(abort_b), .frame_ch(fch_b),
    .frame_diff(fdiff_b), .frame_value(fval_b)
  );

  int n_vec = 0;
  int n_err = 0;
  int half  = 4;

  typedef struct { int sel; bit abort; int ch; bit diff; int unsigned value; } stat_t;
  typedef struct { int sel; int n; logic [63:0] bits; } bits_t;
  stat_t q_stat [$];
  bits_t q_bits [$];
  int          last_ch   [2];
  bit          last_diff [2];
  int unsigned last_val  [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the value an MCP3202-style converter reports for this command.
  function automatic int unsigned model_value(input int sel, input int sgl, input int ch);
    int unsigned a, b;
    if (sel == 0) begin a = chv_a[ch]; b = chv_a[ch ^ 1]; end
    else          begin a = chv_b[ch]; b = chv_b[ch ^ 1]; end
    if (sgl != 0) return a;
    return (a > b) ? a - b : 0;
  endfunction

  task automatic scramble_ch();
    for (int k = 0; k < A_CH; k++) chv_a[k] = $urandom_range(0, (1 << A_RES) - 1);
    for (int k = 0; k < B_CH; k++) chv_b[k] = $urandom_range(0, (1 << B_RES) - 1);
  endtask

  // Status monitor: every pulse must match the oldest queued expectation.
  task automatic mon_pulse(input int sel, input logic d, input logic a, input logic [31:0] ch,
                           input logic dif, input logic [31:0] val);
    stat_t e;
    if (q_stat.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_pulse: dut%0d done=%0b abort=%0b, expected no pulse", sel, d, a);
      return;
    end
    e = q_stat.pop_front();
    check($sformatf("pulse_dut%0d_sel", sel), sel, e.sel);
    check($sformatf("pulse_dut%0d_done", sel), d, !e.abort);
    check($sformatf("pulse_dut%0d_abort", sel), a, e.abort);
    check($sformatf("frame_ch_dut%0d", sel), ch, e.ch);
    check($sformatf("frame_diff_dut%0d", sel), dif, e.diff);
    check($sformatf("frame_value_dut%0d", sel), val, e.value);
  endtask

  always @(negedge clk) begin
    if (done_a || abort_a) mon_pulse(0, done_a, abort_a, 32'(fch_a), fdiff_a, 32'(fval_a));
    if (done_b || abort_b) mon_pulse(1, done_b, abort_b, 32'(fch_b), fdiff_b, 32'(fval_b));
  end

  // MISO sniffer: samples like a master on every rising SCK, compares at CS rise.
  logic [63:0] cap;
  bit          armed = 1'b0;
  bits_t       sn_e;

  always @(negedge cs_a or negedge cs_b) begin
    cap   = '0;
    armed = 1'b1;
  end

  always @(posedge sck) begin
    if (armed) cap = {cap[62:0], (cs_a ? u_if_b.spi_miso : u_if_a.spi_miso)};
  end

  always @(posedge cs_a or posedge cs_b) begin
    if (armed) begin
      armed = 1'b0;
      if (q_bits.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL miso_stream: got 0x%0h, expected no frame", cap);
      end else begin
        sn_e = q_bits.pop_front();
        check($sformatf("miso_stream_dut%0d_%0dbits", sn_e.sel, sn_e.n), cap, sn_e.bits);
      end
    end
  end

  task automatic hp();
    repeat (half) @(negedge clk);
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs_a = v; else cs_b = v;
  endtask

  task automatic clk_bit(input logic m);
    mosi = m;
    hp();
    sck = 1'b1;
    hp();
    sck = 1'b0;
  endtask

  task automatic add_bit(inout bits_t e, input logic b);
    e.bits = {e.bits[62:0], b};
    e.n++;
  endtask

  task automatic check_zero(input int sel, input string tag);
    if (sel == 0) begin
      check({tag, "_miso_a"},  u_if_a.spi_miso, 0);
      check({tag, "_oe_a"},    u_if_a.spi_miso_oe, 0);
      check({tag, "_done_a"},  done_a, 0);
      check({tag, "_abort_a"}, abort_a, 0);
      check({tag, "_ch_a"},    fch_a, 0);
      check({tag, "_diff_a"},  fdiff_a, 0);
      check({tag, "_value_a"}, fval_a, 0);
    end else begin
      check({tag, "_miso_b"},  u_if_b.spi_miso, 0);
      check({tag, "_oe_b"},    u_if_b.spi_miso_oe, 0);
      check({tag, "_done_b"},  done_b, 0);
      check({tag, "_abort_b"}, abort_b, 0);
      check({tag, "_ch_b"},    fch_b, 0);
      check({tag, "_diff_b"},  fdiff_b, 0);
      check({tag, "_value_b"}, fval_b, 0);
    end
  endtask

  // mode: 0 full frame, 1 CS rise after n_arg post-command clocks, 2 CS rise inside the
  // command, 3 RST after n_arg post-command clocks, 4 CS rise while waiting for start.
  task automatic run_frame(input int sel, input int nlead, input int sgl, input int ch,
                           input int msbf, input int extra, input int mode, input int n_arg);
    int          cb, res, nc, n_post;
    int unsigned r;
    bit          seq [$];
    bits_t       eb;
    stat_t       es;
    cb  = (sel == 0) ? A_CB : B_CB;
    res = (sel == 0) ? A_RES : B_RES;
    r   = model_value(sel, sgl, ch);
    seq.push_back(1'b0);
    for (int i = res - 1; i >= 0; i--) seq.push_back(r[i]);
    if (msbf == 0) for (int i = 1; i < res; i++) seq.push_back(r[i]);
    nc     = (mode == 2) ? (n_arg % (cb + 2)) : cb + 2;
    n_post = (mode == 0) ? seq.size() + extra : n_arg % (seq.size() - 1);

    es.sel = sel;
    if (mode == 0) begin
      es.abort = 1'b0; es.ch = ch; es.diff = (sgl == 0); es.value = r;
      last_ch[sel] = ch; last_diff[sel] = (sgl == 0); last_val[sel] = r;
      q_stat.push_back(es);
    end else if (mode == 1 || mode == 2) begin
      es.abort = 1'b1; es.ch = last_ch[sel]; es.diff = last_diff[sel]; es.value = last_val[sel];
      q_stat.push_back(es);
    end

    eb.sel = sel; eb.n = 0; eb.bits = '0;
    set_cs(sel, 1'b0);
    hp();
    check($sformatf("oe_cs_low_dut%0d", sel),
          (sel == 0) ? u_if_a.spi_miso_oe : u_if_b.spi_miso_oe, 1);
    for (int i = 0; i < nlead; i++) begin clk_bit(1'b0); add_bit(eb, 1'b0); end
    if (mode != 4) begin
      clk_bit(1'b1);
      add_bit(eb, 1'b0);
      for (int i = 0; i < nc; i++) begin
        logic b;
        b = (i == 0) ? (sgl != 0) : (i <= cb) ? ch[cb - i] : (msbf != 0);
        clk_bit(b);
        add_bit(eb, 1'b0);
      end
      if (mode != 2) begin
        for (int k = 0; k < n_post; k++) begin
          clk_bit(1'($urandom_range(0, 1)));
          add_bit(eb, (k < seq.size()) ? seq[k] : 1'b0);
          if (mode == 0 && k == 0) scramble_ch();
        end
      end
    end
    hp();

    if (mode == 3) begin
      rst = 1'b1;
      @(negedge clk);
      check_zero(sel, "rst_mid_frame");
      q_bits.push_back(eb);
      set_cs(sel, 1'b1);
      hp();
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin last_ch[s] = 0; last_diff[s] = 1'b0; last_val[s] = 0; end
      hp();
    end else begin
      q_bits.push_back(eb);
      set_cs(sel, 1'b1);
      hp();
      check($sformatf("miso_cs_high_dut%0d", sel),
            (sel == 0) ? u_if_a.spi_miso : u_if_b.spi_miso, 0);
      check($sformatf("oe_cs_high_dut%0d", sel),
            (sel == 0) ? u_if_a.spi_miso_oe : u_if_b.spi_miso_oe, 0);
    end
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel, md, pick, nch;
    scramble_ch();
    for (int s = 0; s < 2; s++) begin last_ch[s] = 0; last_diff[s] = 1'b0; last_val[s] = 0; end
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chv_a[0] = 1000;                   run_frame(0, 0, 1, 0, 1, 0, 0, 0);
    chv_a[1] = 2000;                   run_frame(0, 3, 1, 1, 1, 0, 0, 0);
    chv_a[0] = 'hA5C;                  run_frame(0, 0, 1, 0, 0, 3, 0, 0);
    chv_a[0] = 500;  chv_a[1] = 800;   run_frame(0, 1, 0, 0, 1, 0, 0, 0);
    chv_a[0] = 500;  chv_a[1] = 800;   run_frame(0, 0, 0, 1, 1, 1, 0, 0);
    chv_a[0] = 1234;                   run_frame(0, 0, 1, 0, 1, 0, 1, 6);
    chv_a[1] = 77;                     run_frame(0, 0, 1, 1, 1, 0, 0, 0);
    chv_a[0] = 3000;                   run_frame(0, 1, 1, 0, 1, 0, 3, 5);
    chv_a[0] = 42;                     run_frame(0, 0, 1, 0, 1, 0, 0, 0);
    half = SYNC + 2;
    chv_b[5] = 'h3FF;                  run_frame(1, 0, 1, 5, 1, 0, 0, 0);
    run_frame(1, 2, 0, 3, 0, 1, 0, 0);
    run_frame(0, 0, 1, 0, 1, 0, 2, 1);
    run_frame(0, 2, 1, 0, 1, 0, 4, 0);

    for (int f = 0; f < 40; f++) begin
      sel  = $urandom_range(0, 1);
      pick = $urandom_range(0, 9);
      md   = (pick < 6) ? 0 : (pick < 8) ? 1 : (pick < 9) ? 2 : 4;
      nch  = (sel == 0) ? A_CH : B_CH;
      half = $urandom_range(SYNC + 2, SYNC + 3);
      scramble_ch();
      run_frame(sel, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, nch - 1),
                $urandom_range(0, 1), $urandom_range(0, 2), md, $urandom_range(0, 1000));
    end

    repeat (20) @(negedge clk);
    check("stat_queue_drained", q_stat.size(), 0);
    check("miso_queue_drained", q_bits.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
